// File: rtl/day10_machine_parser.sv
// Parses one ASCII machine line ("[.##.] (3) (1,3) {..}") from an AXI-Stream byte feed into a
// registered record holding the light target and per-button toggle masks.
module day10_machine_parser #(
    parameter int unsigned MAX_NUM_LIGHTS    = 10,
    parameter int unsigned MAX_NUM_BUTTONS   = 13,
    parameter int unsigned MAX_NUM_LIGHTS_W  = MAX_NUM_LIGHTS <= 1 ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int unsigned MAX_NUM_BUTTONS_W =
        MAX_NUM_BUTTONS <= 1 ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
    parameter int unsigned IDX_W             = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [7:0]                                       s_tdata,
    input  logic                                             s_tvalid,
    output logic                                             s_tready,
    input  logic                                             s_tlast,
    output logic                                             rec_valid,
    input  logic                                             rec_accepted,
    output logic [MAX_NUM_LIGHTS_W-1:0]                      num_lights,
    output logic [MAX_NUM_BUTTONS_W-1:0]                     num_buttons,
    output logic [MAX_NUM_LIGHTS-1:0]                        target_lights_arrangement,
    output logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]   buttons,
    output logic                                             rec_error
);

    typedef enum logic [2:0] {
        StIdle, StLights, StGap, StButton, StJolt, StTail, StSkip, StHold
    } state_e;

    localparam logic [7:0] ChLf     = 8'h0a;
    localparam logic [7:0] ChCr     = 8'h0d;
    localparam logic [7:0] ChSpace  = 8'h20;
    localparam logic [7:0] ChHash   = 8'h23;
    localparam logic [7:0] ChLpar   = 8'h28;
    localparam logic [7:0] ChRpar   = 8'h29;
    localparam logic [7:0] ChComma  = 8'h2c;
    localparam logic [7:0] ChDot    = 8'h2e;
    localparam logic [7:0] ChZero   = 8'h30;
    localparam logic [7:0] ChNine   = 8'h39;
    localparam logic [7:0] ChLbrk   = 8'h5b;
    localparam logic [7:0] ChRbrk   = 8'h5d;
    localparam logic [7:0] ChLbrace = 8'h7b;
    localparam logic [7:0] ChRbrace = 8'h7d;

    localparam int unsigned     AccW   = IDX_W + 4;
    localparam logic [IDX_W-1:0] IdxMax = {IDX_W{1'b1}};

    state_e                                           state_q, state_d;
    logic [MAX_NUM_LIGHTS_W-1:0]                      nl_q, nl_d;
    logic [MAX_NUM_BUTTONS_W-1:0]                     nb_q, nb_d;
    logic [MAX_NUM_LIGHTS-1:0]                        tgt_q, tgt_d;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0]   btn_q, btn_d;
    logic [IDX_W-1:0]                                 idx_q, idx_d;
    logic                                             seen_q, seen_d;
    logic                                             err_q, err_d;
    logic                                             valid_q, valid_d;
    logic                                             ready_q, ready_d;

    logic            fire;
    logic            is_digit;
    logic            idx_ok;
    logic            to_skip;
    logic [AccW-1:0] acc;

    always_comb begin
        state_d = state_q;
        nl_d    = nl_q;
        nb_d    = nb_q;
        tgt_d   = tgt_q;
        btn_d   = btn_q;
        idx_d   = idx_q;
        seen_d  = seen_q;
        err_d   = err_q;
        to_skip = 1'b0;

        fire     = s_tvalid && ready_q;
        is_digit = (s_tdata >= ChZero) && (s_tdata <= ChNine);
        acc      = AccW'(idx_q) * AccW'(10) + AccW'(s_tdata[3:0]);
        idx_ok   = seen_q && (32'(idx_q) < 32'(nl_q));

        // Line terminators are handled below, together with the implicit one from s_tlast.
        if (fire && (s_tdata != ChCr) && (s_tdata != ChLf)) begin
            unique case (state_q)
                StIdle: begin
                    nl_d   = '0;
                    nb_d   = '0;
                    tgt_d  = '0;
                    btn_d  = '0;
                    idx_d  = '0;
                    seen_d = 1'b0;
                    err_d  = 1'b0;
                    if (s_tdata == ChLbrk) state_d = StLights;
                    else                   to_skip = 1'b1;
                end
                StLights: begin
                    if ((s_tdata == ChDot) || (s_tdata == ChHash)) begin
                        if (32'(nl_q) >= MAX_NUM_LIGHTS) begin
                            to_skip = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < MAX_NUM_LIGHTS; i++) begin
                                if (32'(nl_q) == i) tgt_d[i] = (s_tdata == ChHash);
                            end
                            nl_d = nl_q + MAX_NUM_LIGHTS_W'(1);
                        end
                    end else if (s_tdata == ChRbrk) begin
                        state_d = StGap;
                    end else begin
                        to_skip = 1'b1;
                    end
                end
                StGap: begin
                    if (s_tdata == ChLpar) begin
                        if (32'(nb_q) >= MAX_NUM_BUTTONS) begin
                            to_skip = 1'b1;
                        end else begin
                            state_d = StButton;
                            idx_d   = '0;
                            seen_d  = 1'b0;
                        end
                    end else if (s_tdata == ChLbrace) begin
                        state_d = StJolt;
                    end else if (s_tdata != ChSpace) begin
                        to_skip = 1'b1;
                    end
                end
                StButton: begin
                    if (is_digit) begin
                        idx_d  = (acc > AccW'(IdxMax)) ? IdxMax : acc[IDX_W-1:0];
                        seen_d = 1'b1;
                    end else if ((s_tdata == ChComma) || (s_tdata == ChRpar)) begin
                        if (!idx_ok) begin
                            to_skip = 1'b1;
                        end else begin
                            for (int unsigned b = 0; b < MAX_NUM_BUTTONS; b++) begin
                                for (int unsigned i = 0; i < MAX_NUM_LIGHTS; i++) begin
                                    if ((32'(nb_q) == b) && (32'(idx_q) == i)) btn_d[b][i] = 1'b1;
                                end
                            end
                            idx_d  = '0;
                            seen_d = 1'b0;
                            if (s_tdata == ChRpar) begin
                                nb_d    = nb_q + MAX_NUM_BUTTONS_W'(1);
                                state_d = StGap;
                            end
                        end
                    end else begin
                        to_skip = 1'b1;
                    end
                end
                StJolt: begin
                    if (s_tdata == ChRbrace) state_d = StTail;
                end
                StTail: begin
                    if (s_tdata != ChSpace) to_skip = 1'b1;
                end
                StSkip: ;
                StHold: ;
                default: to_skip = 1'b1;
            endcase
        end

        if (to_skip) begin
            state_d = StSkip;
            err_d   = 1'b1;
        end

        // End of line: clean finish from GAP/TAIL, error record from any mid-field state.
        if (fire && ((s_tdata == ChLf) || s_tlast)) begin
            unique case (state_d)
                StIdle, StHold: ;
                StGap, StTail: state_d = StHold;
                default: begin
                    state_d = StHold;
                    err_d   = 1'b1;
                end
            endcase
        end

        if ((state_q == StHold) && rec_accepted) begin
            state_d = StIdle;
            err_d   = 1'b0;
        end

        ready_d = (state_d != StHold);
        valid_d = (state_d == StHold);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            nl_q    <= '0;
            nb_q    <= '0;
            tgt_q   <= '0;
            btn_q   <= '0;
            idx_q   <= '0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nl_q    <= nl_d;
            nb_q    <= nb_d;
            tgt_q   <= tgt_d;
            btn_q   <= btn_d;
            idx_q   <= idx_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign s_tready                  = ready_q;
    assign rec_valid                 = valid_q;
    assign rec_error                 = err_q;
    assign num_lights                = nl_q;
    assign num_buttons               = nb_q;
    assign target_lights_arrangement = tgt_q;
    assign buttons                   = btn_q;

endmodule

// File: doc/day10_machine_parser.md
Name: day10_machine_parser

Overview:
- Upstream stage of the day-10 machine configurator. Consumes the puzzle's ASCII byte stream over AXI-Stream.
- Parses one machine line at a time, e.g. "[.##.] (3) (1,3) (2) {3,5,4,7}\n".
- Presents the decoded light target and button wiring as one registered record for the configurator.
- Holds the record until the consumer accepts it, then parses the next line.

Parameters:
- MAX_NUM_LIGHTS, 10, maximum lights per machine.
- MAX_NUM_BUTTONS, 13, maximum buttons per machine.
- MAX_NUM_LIGHTS_W, MAX_NUM_LIGHTS<=1 ? 1 : $clog2(MAX_NUM_LIGHTS+1), light count width.
- MAX_NUM_BUTTONS_W, MAX_NUM_BUTTONS<=1 ? 1 : $clog2(MAX_NUM_BUTTONS+1), button count width.
- IDX_W, 8, width of the decimal index accumulator (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_tdata  in  8  ASCII byte
- s_tvalid  in  1  byte valid
- s_tready  out  1  parser can take a byte
- s_tlast  in  1  last byte of file; treated as an implicit '\n' after the byte
- rec_valid  out  1  record presented
- rec_accepted  in  1  consumer took the record
- num_lights  out  MAX_NUM_LIGHTS_W  lights in the record
- num_buttons  out  MAX_NUM_BUTTONS_W  buttons in the record
- target_lights_arrangement  out  MAX_NUM_LIGHTS  bit i = light i ('#'=1)
- buttons  out  [MAX_NUM_BUTTONS][MAX_NUM_LIGHTS]  buttons[b][i]=1 if button b toggles light i
- rec_error  out  1  record malformed; fields other than counts are undefined

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, s_tready=0 during reset.
  - rec_valid=0, rec_error=0.
  - All counts and vectors cleared to 0.
  - A partially parsed line is discarded.
- Byte transfer: a byte is consumed when s_tvalid && s_tready. s_tready=1 in every state except HOLD.
- '\r' is ignored in all states.
- States and transitions:
  - IDLE: '\n' ignored (blank lines). '[' -> LIGHTS; clear all fields. Any other byte -> SKIP with error set.
  - LIGHTS:
    - '.' or '#' writes bit num_lights, then num_lights++.
    - ']' -> GAP.
    - A light beyond MAX_NUM_LIGHTS -> SKIP with error.
  - GAP:
    - ' ' ignored.
    - '(' -> BUTTON; idx=0; digit_seen=0.
    - '{' -> JOLT.
    - '\n' -> HOLD.
  - BUTTON:
    - Digit: idx = idx*10 + digit, saturating at 2^IDX_W-1; digit_seen=1.
    - ',' or ')': require digit_seen and idx < num_lights, else SKIP with error. Otherwise set buttons[num_buttons][idx] and clear idx/digit_seen.
    - On ')' additionally num_buttons++ and go to GAP.
    - Opening button MAX_NUM_BUTTONS+1 -> SKIP with error.
  - JOLT: contents ignored until '}' -> TAIL.
  - TAIL: ' ' ignored. '\n' -> HOLD. Anything else -> SKIP with error.
  - SKIP: discard until '\n' -> HOLD, with rec_error=1.
  - HOLD: rec_valid=1, s_tready=0. On rec_accepted -> IDLE, clearing rec_valid and rec_error the next cycle.
- s_tlast on any accepted byte behaves as if '\n' followed:
  - in LIGHTS/BUTTON/JOLT -> error record;
  - in GAP/TAIL -> HOLD (the byte itself is processed first);
  - in IDLE it is a no-op.
- Latency: rec_valid rises the cycle after the terminating byte is accepted. Throughput is 1 byte/cycle.
- Outputs are registered and stable throughout HOLD.
- rec_accepted outside HOLD is ignored. Acceptance can occur in the first HOLD cycle, so each record is valid for at least 1 cycle.
- Any other unexpected byte in any state -> SKIP with error.
- A record with num_buttons=0 is valid (no error).

Test Plan:
- Line "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n" -> rec_valid, num_lights=4, target=4'b0110, num_buttons=6, buttons[0..5]=1000,1010,0100,1100,0101,0011, rec_error=0.
- Two lines back to back with rec_accepted held low for 5 cycles -> s_tready=0 for those cycles, record stable; second record appears 1 cycle after its '\n' once the first is accepted.
- MAX_NUM_LIGHTS=16, "[................] (12,15) (0)\n" -> buttons[0]=16'h9000, buttons[1]=16'h0001.
- "[.#] (2)\n" -> rec_error=1 (idx 2 >= num_lights 2); the next good line parses with rec_error=0.
- rst asserted mid-line after "[.#" then "[#.] (1)\n" -> target=2'b01, buttons[0]=2'b10, no residue from the aborted line.
- s_tvalid toggled randomly plus "\r\n" endings and blank lines -> same records as the clean stream. A final line without '\n' but with s_tlast on '}' -> record presented.
